// File: rtl/sram_ot_acc_if.sv
// Writer/reader/control bundle for the output-feature SRAM.
// master = PE array / drain side, slave = the SRAM.
interface sram_ot_acc_if #(
   parameter int DATA_W = 25,
   parameter int ADDR_W = 12
);
   logic                     clr_start;
   logic                     busy;
   logic                     wr_en;
   logic                     wr_acc;
   logic [ADDR_W-1:0]        wr_addr;
   logic signed [DATA_W-1:0] wr_data;
   logic                     rd_en;
   logic [ADDR_W-1:0]        rd_addr;
   logic                     final_flag;
   logic                     rd_valid;
   logic signed [DATA_W-1:0] rd_data;
   logic                     ovf_flag;

   modport master (
      output clr_start, wr_en, wr_acc, wr_addr, wr_data,
      output rd_en, rd_addr, final_flag,
      input  busy, rd_valid, rd_data, ovf_flag
   );

   modport slave (
      input  clr_start, wr_en, wr_acc, wr_addr, wr_data,
      input  rd_en, rd_addr, final_flag,
      output busy, rd_valid, rd_data, ovf_flag
   );
endinterface

// File: rtl/sram_ot_acc.sv
// Output-feature SRAM: saturating accumulate RMW with forwarding,
// ReLU readout port, sticky overflow and a zero-fill sequencer.
module sram_ot_acc #(
   parameter int DEPTH  = 3136,
   parameter int DATA_W = 25,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input logic         clk,
   input logic         rst,
   sram_ot_acc_if.slave bus
);
   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_W:0] DEPTH_L =
      (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST =
      ADDR_W'(DEPTH-1);
   localparam logic signed [DATA_W-1:0] MAXV =
      {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MINV =
      {1'b1, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W-1:0] mem [DEPTH];

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                clr_we;

   logic                s1_valid_q;
   logic                s1_acc_q;
   logic [ADDR_W-1:0]   s1_addr_q;
   logic signed [DATA_W-1:0] s1_data_q;
   logic signed [DATA_W-1:0] s1_old_q;

   logic                ovf_q;
   logic                rd_valid_q;
   logic signed [DATA_W-1:0] rd_data_q;

   logic                idle;
   logic                wr_ok;
   logic                rd_ok;
   logic                rd_in;
   logic                commit;
   logic signed [DATA_W:0]   sum;
   logic                sat_hi, sat_lo;
   logic signed [DATA_W-1:0] s1_res;
   logic signed [DATA_W-1:0] old_v;
   logic signed [DATA_W-1:0] rd_v;

   assign idle  = (state_q == IDLE);
   assign wr_ok = idle && bus.wr_en &&
                  ({1'b0, bus.wr_addr} < DEPTH_L);
   assign rd_ok = idle && bus.rd_en;
   assign rd_in = {1'b0, bus.rd_addr} < DEPTH_L;
   // A write caught by the first clear cycle is dropped;
   // the clear zeroes that word anyway.
   assign commit = s1_valid_q && idle;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.clr_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = IDLE;
         end
         default: ;
      endcase
   end

   always_comb begin
      sum = {s1_old_q[DATA_W-1], s1_old_q} +
            {s1_data_q[DATA_W-1], s1_data_q};
      sat_hi = s1_acc_q && !sum[DATA_W] && sum[DATA_W-1];
      sat_lo = s1_acc_q && sum[DATA_W] && !sum[DATA_W-1];
      if (sat_hi)        s1_res = MAXV;
      else if (sat_lo)   s1_res = MINV;
      else if (s1_acc_q) s1_res = sum[DATA_W-1:0];
      else               s1_res = s1_data_q;
   end

   always_comb begin
      old_v = mem[bus.wr_addr];
      if (s1_valid_q && s1_addr_q == bus.wr_addr)
         old_v = s1_res;
      rd_v = '0;
      if (rd_in) begin
         rd_v = mem[bus.rd_addr];
         if (commit && s1_addr_q == bus.rd_addr)
            rd_v = s1_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_acc_q   <= 1'b0;
         s1_addr_q  <= '0;
         s1_data_q  <= '0;
         s1_old_q   <= '0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s1_valid_q <= wr_ok;
         if (wr_ok) begin
            s1_acc_q  <= bus.wr_acc;
            s1_addr_q <= bus.wr_addr;
            s1_data_q <= bus.wr_data;
            s1_old_q  <= old_v;
         end
         if (idle && bus.clr_start)
            ovf_q <= 1'b0;
         else if (commit && (sat_hi || sat_lo))
            ovf_q <= 1'b1;
         rd_valid_q <= rd_ok;
         if (rd_ok) begin
            if (bus.final_flag && rd_v[DATA_W-1])
               rd_data_q <= '0;
            else
               rd_data_q <= rd_v;
         end
      end
   end

   // Array has no reset; rst forces IDLE and kills stage 1
   // asynchronously, so no write slips through.
   always_ff @(posedge clk) begin
      if (clr_we)
         mem[cnt_q] <= '0;
      else if (commit)
         mem[s1_addr_q] <= s1_res;
   end

   assign bus.busy     = !idle;
   assign bus.ovf_flag = ovf_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_sram_ot_acc.sv
// Bench for sram_ot_acc: sequential memory model plus
// directed vectors with literal expectations.
module tb_sram_ot_acc;
   localparam int DEPTH = 3136;
   localparam int DW    = 25;
   localparam int AW    = 12;
   localparam int MAXV  = 16777215;
   localparam int MINV  = -16777216;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_ot_acc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   sram_ot_acc #(
      .DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int ncmp = 0;
   int nfail = 0;

   task automatic chk(input string nm, input int act,
                      input int exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
      end
   endtask

   // Model: each accepted write takes effect at once in
   // program order; a read sees all earlier writes.
   int  mem_m [DEPTH];
   int  clr_left;
   bit  exp_v;
   int  exp_d;
   bit  ovf_m;
   bit  pend_ovf;

   always @(posedge clk or posedge rst) begin
      int v;
      longint s;
      if (rst) begin
         clr_left <= 0;
         exp_v    <= 1'b0;
         exp_d    <= 0;
         ovf_m    <= 1'b0;
         pend_ovf <= 1'b0;
      end else if (clr_left > 0) begin
         mem_m[DEPTH-clr_left] <= 0;
         clr_left <= clr_left - 1;
         exp_v    <= 1'b0;
         ovf_m    <= ovf_m | pend_ovf;
         pend_ovf <= 1'b0;
      end else begin
         ovf_m    <= ovf_m | pend_ovf;
         pend_ovf <= 1'b0;
         exp_v    <= bus.rd_en;
         if (bus.rd_en) begin
            v = (bus.rd_addr < DEPTH) ?
                mem_m[bus.rd_addr] : 0;
            exp_d <= (bus.final_flag && v < 0) ? 0 : v;
         end
         if (bus.wr_en && bus.wr_addr < DEPTH) begin
            if (bus.wr_acc) begin
               s = longint'(mem_m[bus.wr_addr]) +
                   longint'(int'(bus.wr_data));
               if (s > MAXV) begin
                  mem_m[bus.wr_addr] <= MAXV;
                  pend_ovf <= 1'b1;
               end else if (s < MINV) begin
                  mem_m[bus.wr_addr] <= MINV;
                  pend_ovf <= 1'b1;
               end else begin
                  mem_m[bus.wr_addr] <= int'(s);
               end
            end else begin
               mem_m[bus.wr_addr] <= int'(bus.wr_data);
            end
         end
         if (bus.clr_start) begin
            clr_left <= DEPTH;
            ovf_m    <= 1'b0;
            pend_ovf <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", int'(bus.busy), int'(clr_left > 0));
         chk("ovf_flag", int'(bus.ovf_flag), int'(ovf_m));
         chk("rd_valid", int'(bus.rd_valid), int'(exp_v));
         chk("rd_data", int'(bus.rd_data), exp_d);
      end
   end

   task automatic idle_in();
      bus.clr_start  = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_acc     = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
      bus.final_flag = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      idle_in();
   endtask

   task automatic wr(input int a, input int d, input bit acc);
      bus.wr_en   = 1'b1;
      bus.wr_acc  = acc;
      bus.wr_addr = AW'(a);
      bus.wr_data = DW'(d);
   endtask

   task automatic rd(input int a, input bit fin);
      bus.rd_en      = 1'b1;
      bus.rd_addr    = AW'(a);
      bus.final_flag = fin;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (bus.busy && n < DEPTH + 10) begin
         n++;
         @(negedge clk);
      end
      chk(nm, int'(bus.busy), 0);
   endtask

   initial begin
      int n;
      idle_in();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rd_valid", int'(bus.rd_valid), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_ovf", int'(bus.ovf_flag), 0);
      rst = 1'b0;
      @(negedge clk);

      // full clear with writes/reads attempted while busy
      bus.clr_start = 1'b1;
      tick();
      wr(200, 55, 1'b0);
      rd(200, 1'b0);
      n = 0;
      while (bus.busy && n < DEPTH + 10) begin
         n++;
         @(negedge clk);
         if (n == 3) idle_in();
      end
      chk("clear_len", n, DEPTH);
      for (int a = 0; a < DEPTH; a++) begin
         rd(a, 1'b0);
         tick();
      end
      rd(200, 1'b0); tick();
      chk("busy_wr_dropped", int'(bus.rd_data), 0);

      // overwrite then read
      wr(5, 'h123, 1'b0); tick();
      tick();
      rd(5, 1'b0); tick();
      chk("ovr_valid", int'(bus.rd_valid), 1);
      chk("ovr_data", int'(bus.rd_data), 'h123);

      // back-to-back accumulate
      wr(100, 10, 1'b1); tick();
      wr(100, 20, 1'b1); tick();
      wr(100, -5, 1'b1); tick();
      tick();
      rd(100, 1'b0); tick();
      chk("acc_b2b", int'(bus.rd_data), 25);
      chk("acc_ovf", int'(bus.ovf_flag), 0);

      // positive saturation, then clear resets ovf
      wr(7, 16777200, 1'b0); tick();
      wr(7, 100, 1'b1); tick();
      tick();
      rd(7, 1'b0); tick();
      chk("sat_hi", int'(bus.rd_data), MAXV);
      chk("sat_hi_ovf", int'(bus.ovf_flag), 1);
      bus.clr_start = 1'b1; tick();
      chk("clr_ovf", int'(bus.ovf_flag), 0);
      wait_idle("clr2_timeout");

      // negative saturation
      wr(8, MINV, 1'b0); tick();
      wr(8, -1, 1'b1); tick();
      tick();
      rd(8, 1'b0); tick();
      chk("sat_lo", int'(bus.rd_data), MINV);
      chk("sat_lo_ovf", int'(bus.ovf_flag), 1);

      // ReLU readout
      wr(3, -42, 1'b0); tick();
      wr(4, 42, 1'b0); tick();
      tick();
      rd(3, 1'b0); tick();
      chk("relu_off", int'(bus.rd_data), -42);
      rd(3, 1'b1); tick();
      chk("relu_neg", int'(bus.rd_data), 0);
      rd(4, 1'b1); tick();
      chk("relu_pos", int'(bus.rd_data), 42);

      // write-first collision, then read alongside acceptance
      wr(9, 1, 1'b0); tick();
      tick();
      wr(9, 77, 1'b0); tick();
      rd(9, 1'b0); wr(9, 5, 1'b1); tick();
      chk("wr_first", int'(bus.rd_data), 77);
      rd(9, 1'b0); tick();
      chk("fwd_acc", int'(bus.rd_data), 82);

      // out of range
      wr(3200, 99, 1'b1); tick();
      rd(3200, 1'b0); tick();
      chk("oor_valid", int'(bus.rd_valid), 1);
      chk("oor_data", int'(bus.rd_data), 0);
      rd(4095, 1'b1); tick();
      chk("oor_top", int'(bus.rd_data), 0);

      // reset aborts clear after 10 words
      wr(10, 1234, 1'b0); tick();
      tick();
      tick();
      bus.clr_start = 1'b1; tick();
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("abort_busy", int'(bus.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int a = 0; a <= 10; a++) begin
         rd(a, 1'b0); tick();
         chk("abort_word", int'(bus.rd_data),
             (a == 10) ? 1234 : 0);
      end
      rd(5, 1'b0); tick();
      chk("abort_w5", int'(bus.rd_data), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/sram_ot_acc.md
Name: sram_ot_acc

Overview:
- Parametrised output-feature SRAM for the conv datapath. Successor to the fixed 3136x25 output buffer.
- Adds an accumulate mode: a pipelined read-modify-write with saturation and forwarding, so partial sums from successive input channels add in place.
- Adds a separate read port with optional ReLU on final readout, a sticky overflow flag, and a clear sequencer that zeroes the array.
- Sits between the PE array (writer) and the result drain or DMA (reader).

Parameters:
- DEPTH, 3136, number of words.
- DATA_W, 25, signed two's-complement word width.
- ADDR_W, $clog2(DEPTH), address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clr_start  in  1  pulse: start the zero-fill sequence and clear ovf_flag.
- busy  out  1  high while clear is in progress.
- wr_en  in  1  write request.
- wr_acc  in  1  1: mem += wr_data; 0: mem = wr_data.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  signed write operand.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- final_flag  in  1  sampled with rd_en; 1 applies ReLU to the returned word.
- rd_valid  out  1  rd_data valid (one cycle after rd_en).
- rd_data  out  DATA_W  read result.
- ovf_flag  out  1  sticky: set when any accumulate saturated.

Behaviour:
- Reset (async): rd_data=0, rd_valid=0, busy=0, ovf_flag=0, write stage-1 valid=0, FSM=IDLE, clear counter=0. Array contents are not reset.
- FSM states: IDLE, CLEAR.
  - IDLE->CLEAR on clr_start. That same edge sets ovf_flag=0 and counter=0.
  - In CLEAR: one word per cycle, mem[counter]<=0, counter increments. busy=1 from the cycle after clr_start.
  - CLEAR->IDLE on the edge that writes word DEPTH-1; busy drops the following cycle. The clear takes exactly DEPTH cycles.
  - clr_start while busy is ignored.
  - wr_en and rd_en are ignored while busy; rd_valid stays 0.
- Write pipeline, 2 stages; wr_en accepted only in IDLE.
  - Stage 0 (cycle T): old = mem[wr_addr]. If stage 1 is valid with the same address, old = the stage-1 result (forwarding).
  - Stage 0 registers addr, data, acc and old at the T edge.
  - Stage 1 (cycle T+1): result = acc ? sat(old+data) : data. mem[addr]<=result on the T+1 edge.
  - Back-to-back accumulates to one address, one per cycle, lose no updates.
- Saturation: compute the sum in DATA_W+1 bits.
  - Sum > 2^(DATA_W-1)-1 clamps to the maximum; sum < -2^(DATA_W-1) clamps to the minimum.
  - Either clamp sets ovf_flag on the commit edge.
  - Overwrite never sets ovf_flag.
- Read port, latency 1.
  - rd_en in cycle R: on the R edge, rd_data<=f(v), rd_valid<=1.
  - v = mem[rd_addr], except when stage 1 commits to the same address in cycle R: then v = the stage-1 result (write-first).
  - f(v) = (final_flag && v<0) ? 0 : v.
  - With no rd_en: rd_valid<=0 and rd_data holds its value.
- Simultaneous read and write to different addresses are independent. A read never stalls a write.
- Out-of-range addresses (>= DEPTH):
  - Writes are dropped, with no ovf effect.
  - Reads return rd_data=0 with rd_valid=1.
- rst asserted mid-CLEAR aborts the clear. Words already zeroed stay zero; the rest are untouched. A pending stage-1 write is discarded.

Test Plan:
- Overwrite and read: write 0x0000123 to addr 5 (acc=0) at T; rd_en addr 5 at T+2 -> rd_valid at T+3, rd_data=0x0000123.
- Back-to-back accumulate: after clear, write acc=1 with data 10, 20, -5 to addr 100 on consecutive cycles; read 2 cycles after the last -> 25, ovf_flag=0.
- Saturation (DATA_W=25):
  - addr 7 = 16777200, accumulate +100 -> reads 16777215, ovf_flag=1.
  - Then clr_start -> ovf_flag=0.
  - Separately, -16777216 accumulate -1 -> reads -16777216.
- ReLU readout: mem[3]=-42. rd_en with final_flag=0 -> -42; with final_flag=1 -> 0. mem[4]=+42 with final_flag=1 -> 42.
- Write-first collision: stage-1 commit of 77 to addr 9 in the same cycle as rd_en addr 9 (old value 1) -> rd_data=77.
- Clear and reset abort:
  - clr_start -> busy high for exactly DEPTH cycles; all words read 0 afterwards; wr_en during busy has no effect.
  - Repeat with rst after 10 cycles -> busy=0 immediately; words 0..9 read 0, word 10 keeps its prior value.
